// File: rtl/counter7sd_pkg.sv
// Shared constants for the multi-digit BCD counter with 7-segment scan output.
// Segment patterns are abcdefg, active-high (bit 6 = a, bit 0 = g).
package counter7sd_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_H   = 7'b0110111;
    localparam logic [6:0] SEG_P   = 7'b1100111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Counter mode. PAUSED remembers where it came from in a separate flag.
    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to abcdefg decoder. Codes 10..15 never come from the
// counter; they decode to all segments off.
module seg7_decode
    import counter7sd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Plain lookup of the digit pattern.
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/counter7sd_multi.sv
// Multi-digit BCD up/down counter with a multiplexed 7-segment display.
// A prescaler produces a count tick every TICK_DIV cycles; a scan counter
// steps the one-hot digit enable every SCAN_DIV cycles.
// Optional build macro COUNTER7SD_LEADING_BLANK_EN blanks leading zero
// digits (never digit 0) while counting.
// state_dbg exposes the FSM state for observation.
module counter7sd_multi
    import counter7sd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 4,
    parameter int SCAN_DIV = 2
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  reverse,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output state_t                state_dbg
);

    localparam int VW     = 4 * DIGITS;
    localparam int PSC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

    state_t            state_q, state_d;
    logic              resume_run_q, resume_run_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [VW-1:0]     value_q, value_d;
    logic              wrap_q, wrap_d;
    logic [VW-1:0]     step_value, all_nines, one_val;
    logic              step_wrap;
    logic              tick;
    logic [SCAN_W-1:0] scan_q;
    logic [SLOT_W-1:0] slot_q;
    logic [DIGITS-1:0] sel_q;
    logic [3:0]        cur_digit;
    logic              blank;
    logic [6:0]        dec_seg, seg_d, seg_q;

    // The prescaler only advances while running, so pause freezes it.
    assign tick = pause && (psc_q == PSC_LAST);

    // Ripple BCD increment/decrement of the whole value, plus load constants.
    always_comb begin
        logic       ripple;
        logic [3:0] d;
        ripple     = 1'b1;
        d          = 4'd0;
        step_value = value_q;
        all_nines  = '0;
        one_val    = '0;
        one_val[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all_nines[4*i +: 4] = 4'd9;
            d = value_q[4*i +: 4];
            if (ripple) begin
                if (!reverse) begin
                    if (d == 4'd9) begin
                        step_value[4*i +: 4] = 4'd0;
                    end else begin
                        step_value[4*i +: 4] = d + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        step_value[4*i +: 4] = 4'd9;
                    end else begin
                        step_value[4*i +: 4] = d - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        // A carry/borrow out of the top digit is the decimal wrap.
        step_wrap = ripple;
    end

    // Next-state logic: pause wins over a coincident tick.
    always_comb begin
        state_d      = state_q;
        resume_run_d = resume_run_q;
        psc_d        = psc_q;
        value_d      = value_q;
        wrap_d       = 1'b0;
        case (state_q)
            HOLD, RUN: begin
                if (!pause) begin
                    state_d      = PAUSED;
                    resume_run_d = (state_q == RUN);
                end else begin
                    psc_d = tick ? '0 : psc_q + 1'b1;
                    if (tick) begin
                        if (state_q == HOLD) begin
                            state_d = RUN;
                            value_d = reverse ? all_nines : one_val;
                        end else begin
                            value_d = step_value;
                            wrap_d  = step_wrap;
                        end
                    end
                end
            end
            PAUSED: begin
                // Restart the prescaler so the first tick is a full period away.
                if (pause) begin
                    state_d = resume_run_q ? RUN : HOLD;
                    psc_d   = '0;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // FSM, prescaler, count value and wrap pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= HOLD;
            resume_run_q <= 1'b0;
            psc_q        <= '0;
            value_q      <= '0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            resume_run_q <= resume_run_d;
            psc_q        <= psc_d;
            value_q      <= value_d;
            wrap_q       <= wrap_d;
        end
    end

    // Scan counter: dwell SCAN_DIV cycles on each slot, digit 0 first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_q <= '0;
            slot_q <= '0;
            sel_q  <= DIGITS'(1);
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            if (slot_q == SLOT_LAST) begin
                slot_q <= '0;
                sel_q  <= DIGITS'(1);
            end else begin
                slot_q <= slot_q + 1'b1;
                sel_q  <= sel_q << 1;
            end
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // Select the digit for the current slot and decide whether it is blanked.
    always_comb begin
        cur_digit = value_q[3:0];
        blank     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_digit = value_q[4*i +: 4];
`ifdef COUNTER7SD_LEADING_BLANK_EN
                blank = (i != 0);
                for (int j = i; j < DIGITS; j++) begin
                    if (value_q[4*j +: 4] != 4'd0) blank = 1'b0;
                end
`else
                blank = 1'b0;
`endif
            end
        end
    end

    seg7_decode u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Mode letters override the decoded digit; blanking applies only in RUN.
    always_comb begin
        seg_d = dec_seg;
        case (state_q)
            HOLD:    seg_d = SEG_H;
            PAUSED:  seg_d = SEG_P;
            default: seg_d = blank ? SEG_OFF : dec_seg;
        endcase
    end

    // Segment output register: one cycle behind value and slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_H;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;
    assign value     = value_q;
    assign wrap      = wrap_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_counter7sd_multi.sv
// Bench for counter7sd_multi. Instance A (2 digits, tick every cycle) is
// checked every cycle against an arithmetic model; instance B (4 digits,
// slow tick, 3-cycle scan) is checked with literal scan/display vectors.
`timescale 1ns/1ps
module tb_counter7sd_multi;
  import counter7sd_pkg::*;

  localparam int AD = 2, AT = 1, AS = 2;
  localparam int BD = 4, BT = 16, BS = 3;
  localparam int AMAX = 99;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, pause_a = 1'b1, rev_a = 1'b0;
  logic rst_b = 1'b1, pause_b = 1'b1, rev_b = 1'b0;
  logic chk_a = 1'b0;

  logic [6:0]      seg_a, seg_b;
  logic [AD-1:0]   sel_a;
  logic [BD-1:0]   sel_b;
  logic [4*AD-1:0] val_a;
  logic [4*BD-1:0] val_b;
  logic            wrap_a, wrap_b;
  state_t          st_a, st_b;

  counter7sd_multi #(.DIGITS(AD), .TICK_DIV(AT), .SCAN_DIV(AS)) dut_a (
    .clock(clk), .reset(rst_a), .pause(pause_a), .reverse(rev_a),
    .seg(seg_a), .digit_sel(sel_a), .value(val_a), .wrap(wrap_a), .state_dbg(st_a)
  );

  counter7sd_multi #(.DIGITS(BD), .TICK_DIV(BT), .SCAN_DIV(BS)) dut_b (
    .clock(clk), .reset(rst_b), .pause(pause_b), .reverse(rev_b),
    .seg(seg_b), .digit_sel(sel_b), .value(val_b), .wrap(wrap_b), .state_dbg(st_b)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // mode: 0 hold, 1 run, 2 paused
  function automatic logic [6:0] exp_seg(input int mode, input int v, input int slot);
    int p;
    p = 1;
    for (int i = 0; i < slot; i++) p = p * 10;
    if (mode == 0) return 7'b0110111;
    if (mode == 2) return 7'b1100111;
`ifdef COUNTER7SD_LEADING_BLANK_EN
    if (slot > 0 && v < p) return 7'b0000000;
`endif
    return seg_of((v / p) % 10);
  endfunction

  // behavioural model of instance A
  int m_val = 0, m_mode = 0, m_prior = 0, m_psc = 0, m_cyc = 0;
  bit m_wrap = 1'b0;
  logic [6:0] m_seg = 7'b0110111;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      m_val = 0; m_mode = 0; m_prior = 0; m_psc = 0; m_cyc = 0;
      m_wrap = 1'b0; m_seg = 7'b0110111;
    end else begin
      bit tk;
      m_seg = exp_seg(m_mode, m_val, (m_cyc / AS) % AD);
      m_wrap = 1'b0;
      if (m_mode == 2) begin
        if (pause_a) begin m_mode = m_prior; m_psc = 0; end
      end else if (!pause_a) begin
        m_prior = m_mode;
        m_mode = 2;
      end else begin
        tk = (m_psc == AT - 1);
        m_psc = (m_psc + 1) % AT;
        if (tk) begin
          if (m_mode == 0) begin
            m_mode = 1;
            m_val = rev_a ? AMAX : 1;
          end else if (rev_a) begin
            if (m_val == 0) begin m_val = AMAX; m_wrap = 1'b1; end
            else m_val = m_val - 1;
          end else begin
            if (m_val == AMAX) begin m_val = 0; m_wrap = 1'b1; end
            else m_val = m_val + 1;
          end
        end
      end
      m_cyc = m_cyc + 1;
    end
  end

  // scoreboard compare for instance A, every cycle
  always @(negedge clk) begin
    if (chk_a) begin
      check("a_value", 32'(val_a), to_bcd(m_val));
      check("a_wrap", 32'(wrap_a), 32'(m_wrap));
      check("a_digit_sel", 32'(sel_a), 32'(1) << ((m_cyc / AS) % AD));
      check("a_seg", 32'(seg_a), 32'(m_seg));
    end
  end

  // stimulus
  logic [3:0] sel_tab [13];
  int n_wrap;
  int n;
  logic [BD-1:0] prev_sel;
  logic [6:0] want;

  initial begin
    sel_tab = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd1};
    #1 rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk_a = 1'b1;

    // reset state
    check("rst_value", 32'(val_a), 32'h0);
    check("rst_seg", 32'(seg_a), 32'b0110111);
    check("rst_digit_sel", 32'(sel_a), 32'b01);
    check("rst_wrap", 32'(wrap_a), 32'h0);
    check("rst_state", 32'(st_a), 32'(HOLD));
    check("rst_b_sel", 32'(sel_b), 32'b0001);

    // instance B: scan sequence then the 0007 display
    rst_b = 1'b1;
    for (int k = 0; k < 13; k++) begin
      check("b_digit_sel", 32'(sel_b), 32'(sel_tab[k]));
      @(negedge clk);
    end
    n = 0;
    while (val_b !== 16'h0007 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b_reach_0007", 32'(val_b), 32'h0007);
    for (int k = 0; k < 14; k++) begin
      prev_sel = sel_b;
      @(negedge clk);
      if (prev_sel == 4'b0001) want = 7'b1110000;
`ifdef COUNTER7SD_LEADING_BLANK_EN
      else want = 7'b0000000;
`else
      else want = 7'b1111110;
`endif
      check("b_seg_0007", 32'(seg_b), 32'(want));
      check("b_hold_0007", 32'(val_b), 32'h0007);
    end

    // instance A: full up count 00..99..00
    rst_a = 1'b1;
    @(negedge clk);
    check("a_first_01", 32'(val_a), 32'h01);
    n_wrap = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wrap_a) n_wrap++;
      if (i == 97) check("a_reach_99", 32'(val_a), 32'h99);
      if (i == 98) begin
        check("a_up_wrap_val", 32'(val_a), 32'h00);
        check("a_up_wrap_pulse", 32'(wrap_a), 32'h1);
      end
    end
    check("a_wrap_once", 32'(n_wrap), 32'd1);

    // pause at 37
    n = 0;
    while (val_a !== 8'h37 && n < 120) begin
      @(negedge clk);
      n++;
    end
    check("a_reach_37", 32'(val_a), 32'h37);
    pause_a = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("pause_value", 32'(val_a), 32'h37);
      check("pause_state", 32'(st_a), 32'(PAUSED));
      if (j >= 1) check("pause_seg", 32'(seg_a), 32'b1100111);
    end
    pause_a = 1'b1;
    @(negedge clk);
    check("resume_no_count", 32'(val_a), 32'h37);
    @(negedge clk);
    check("resume_38", 32'(val_a), 32'h38);

    // pause from HOLD, then count down
    #2 rst_a = 1'b0;
    @(negedge clk);
    rev_a = 1'b1; pause_a = 1'b0; rst_a = 1'b1;
    @(negedge clk);
    check("hold_pause_state", 32'(st_a), 32'(PAUSED));
    @(negedge clk);
    check("hold_pause_seg", 32'(seg_a), 32'b1100111);
    pause_a = 1'b1;
    @(negedge clk);
    check("hold_resume_state", 32'(st_a), 32'(HOLD));
    @(negedge clk);
    check("down_first_99", 32'(val_a), 32'h99);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 98) check("down_reach_00", 32'(val_a), 32'h00);
      if (i == 99) begin
        check("down_wrap_val", 32'(val_a), 32'h99);
        check("down_wrap_pulse", 32'(wrap_a), 32'h1);
      end
    end
    rev_a = 1'b0;

    // async reset at 52, between edges
    n = 0;
    while (val_a !== 8'h52 && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("a_reach_52", 32'(val_a), 32'h52);
    #2 rst_a = 1'b0;
    #1;
    check("async_value", 32'(val_a), 32'h0);
    check("async_seg", 32'(seg_a), 32'b0110111);
    check("async_sel", 32'(sel_a), 32'b01);
    check("async_wrap", 32'(wrap_a), 32'h0);
    check("async_state", 32'(st_a), 32'(HOLD));
    @(negedge clk);
    rst_a = 1'b1;
    repeat (5) @(negedge clk);
    check("restart_05", 32'(val_a), 32'h05);

    chk_a = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter7sd_multi.md
COUNTER7SD_MULTI -- requirements
Module: counter7sd_multi

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 4: clock cycles per count step, minimum 1.
REQ-003 SHALL have parameter SCAN_DIV, default 2: clock cycles per display digit slot, minimum 1.
REQ-004 SHALL have port clock, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port pause, input, 1: active-low; 0 = paused.
REQ-007 SHALL have port reverse, input, 1: count direction; 0 = up, 1 = down.
REQ-008 SHALL have port seg, output, 7: segment pattern in abcdefg order, active-high, registered.
REQ-009 SHALL have port digit_sel, output, DIGITS: one-hot digit enable, registered.
REQ-010 SHALL have port value, output, 4*DIGITS: BCD count; digit 0 is in the LSBs.
REQ-011 SHALL have port wrap, output, 1: one-cycle pulse on decimal wrap-around.

Function
REQ-012 SHALL use a prescaler that asserts an internal tick every TICK_DIV cycles; the prescaler is frozen while pause=0.
REQ-013 SHALL implement the FSM states HOLD, RUN and PAUSED.
REQ-014 HOLD: value=0; seg shows H (0110111) in every slot.
REQ-015 HOLD to RUN on a tick with pause=1: value loads 0..01 if reverse=0, or 9..99 if reverse=1.
REQ-016 RUN: on each tick, value increments (reverse=0) or decrements (reverse=1) as a DIGITS-digit BCD number with ripple carry/borrow; reverse is sampled only at the tick.
REQ-017 Up wrap: 9..99 to 0..00 SHALL pulse wrap for the cycle after the tick.
REQ-018 Down wrap: 0..00 to 9..99 SHALL pulse wrap for the cycle after the tick.
REQ-019 pause=0 in HOLD or RUN SHALL enter PAUSED on the next edge: value held, seg shows P (1100111) in every slot, scanning continues.
REQ-020 pause=1 in PAUSED SHALL return to the prior state (HOLD or RUN); the first tick after resuming is a full TICK_DIV later.
REQ-021 A tick and pause=0 in the same cycle: pause wins and no count occurs.
REQ-022 The scan counter SHALL advance digit_sel one position every SCAN_DIV cycles, from digit 0 to DIGITS-1, then wrap to 0.
REQ-023 seg SHALL show the decoded digit selected by digit_sel, with one cycle of latency from value or slot change.
REQ-024 BCD digits of 10..15 SHALL never occur; the decoder maps them to all-off (0000000).
REQ-025 DIGITS=1 SHALL hold digit_sel constant at 1.

Reset
REQ-026 reset=0 SHALL asynchronously force: state=HOLD, value=0, wrap=0, seg=0110111, digit_sel=one-hot digit 0, prescaler=0, scan counter=0.
REQ-027 Reset asserted mid-count or mid-pause SHALL abandon all state; after release, counting restarts per REQ-015.

Configuration
REQ-028 Macro COUNTER7SD_LEADING_BLANK_EN, when defined, SHALL blank (0000000) zero digits above the most-significant nonzero digit in RUN; digit 0 is never blanked.
REQ-029 Without COUNTER7SD_LEADING_BLANK_EN, all digits SHALL always display, zeros included.
REQ-030 H and P patterns SHALL never be blanked.

Structure
REQ-031 Package counter7sd_pkg SHALL hold the segment constants SEG_0..SEG_9 (3=1111001, 6=1011111, otherwise standard), SEG_H, SEG_P, SEG_OFF and the FSM state enum.
REQ-032 Sub-module seg7_decode SHALL be combinational, converting 4-bit BCD to 7-bit abcdefg; it is instantiated once on the muxed digit.

Verification
REQ-033 DIGITS=2, TICK_DIV=1: release reset with pause=1, reverse=0 -> value 00 (HOLD, seg=H), then 01, 02 ... 99, 00 with wrap=1 exactly once.
REQ-034 DIGITS=2, reverse=1 from HOLD -> first value 99; value 00 then next tick gives 99 with a wrap pulse.
REQ-035 Count to 37, drive pause=0 for 10 cycles -> value stays 37, seg=1100111 in both slots; release -> 38 after TICK_DIV cycles.
REQ-036 Drop reset asynchronously between edges at value 52 -> outputs reach the REQ-026 values immediately, before the next edge.
REQ-037 DIGITS=4, value 0007, macro defined -> slots 3..1 show 0000000 and slot 0 shows 1110000; macro undefined -> slots 3..1 show 1111110.
REQ-038 SCAN_DIV=3, DIGITS=4 -> digit_sel sequence 0001, 0010, 0100, 1000, each held 3 cycles, repeating.
